divisor_ctrl: RTL and testbench
===============================

// Module: divisor_ctrl
// PURPOSE
//  Sequencer between the keypad scanner, the integer divider and the 7-seg display driver.
//  Collects hex key digits into operands A and B, then issues one start to the divider.
//  Waits for the divider result and publishes quotient/remainder (or an error code) for display.
//  Sits in top_divisor between the keypad decoder (key_valid/key_code) and the divider core.
// PARAMETERS
//  W        8        operand width in bits; must be a multiple of 4; DIGITS = W/4 keys per operand
//  TIMEOUT  1024     max clk cycles from div_start to div_done before declaring error
// PORTS
//  clk         in   1    system clock; single clock domain
//  rst         in   1    synchronous reset, active-high
//  key_valid   in   1    one-cycle pulse per debounced key press
//  key_code    in   4    key id: 0x0-0xD hex digit, 0xE '*' = clear, 0xF '#' = toggle view
//  div_busy    in   1    divider is computing
//  div_done    in   1    one-cycle pulse; div_q/div_r valid in that cycle only
//  div_q       in   W    quotient
//  div_r       in   W    remainder
//  div_start   out  1    one-cycle start pulse
//  div_a       out  W    dividend; held stable from start until done
//  div_b       out  W    divisor; held stable from start until done
//  disp_value  out  2W   value to display; high half = left digits
//  disp_blank  out  2W/4 per-nibble blank (1 = digit off)
//  disp_err    out  1    error indication ("Err" pattern selected by display driver)
// BEHAVIOUR
//  Reset:
//   - state = LOAD_A; A = B = 0; digit count = 0.
//   - div_start = 0; disp_value = 0; disp_blank = all 1; disp_err = 0; view = quotient/remainder.
//  Entry:
//   - In LOAD_A/LOAD_B, a digit key shifts left: X <= {X[W-5:0], key_code}; count++.
//   - After DIGITS digits in LOAD_A: go to LOAD_B with count = 0.
//   - After DIGITS digits in LOAD_B: go to CHECK.
//  CHECK (1 cycle):
//   - B == 0 -> ERR.
//   - Otherwise -> START.
//  START:
//   - Assert div_start for exactly 1 cycle, only while div_busy == 0; hold in START while busy.
//   - Then go to WAIT and clear the timeout counter.
//  WAIT:
//   - div_done -> capture q, r; go to SHOW.
//   - Counter reaches TIMEOUT-1 without done -> ERR.
//   - Latency: key -> start = 2 cycles when idle; done -> disp update = 1 cycle.
//  SHOW:
//   - view = QR: disp_value = {q, r}.
//   - '#' toggles view to AB: disp_value = {A, B}.
//   - A digit key starts a new entry: A = {0, digit}, count = 1, state = LOAD_A.
//  ERR:
//   - disp_err = 1, disp_blank = 0.
//   - Any digit key restarts like SHOW; '*' clears.
//  Display while loading:
//   - LOAD_A: disp_value = {A, 0}; only the entered A nibbles are unblanked.
//   - LOAD_B: disp_value = {A, B}; all A nibbles plus the entered B nibbles are unblanked.
//  Clear '*':
//   - In any state: go to LOAD_A, A = B = 0, count = 0, disp_err = 0, all blank.
//   - In START/WAIT also set the drop flag: the next div_done is discarded and the flag cleared.
//  Ignored events:
//   - '#' outside SHOW.
//   - div_done outside WAIT, and div_done with the drop flag set.
//   - Key pulses in CHECK/START/WAIT other than '*'.
//  Simultaneous events:
//   - key_valid '*' and div_done in the same cycle -> clear wins; result discarded.
//   - div_done and timeout in the same cycle -> done wins.
//  Reset mid-operation:
//   - Returns to the reset state in the next cycle.
//   - div_start is never asserted in the reset cycle.
// STRUCTURE
//  divisor_pkg:
//   - ctrl_state_t enum {LOAD_A, LOAD_B, CHECK, START, WAIT, SHOW, ERR}.
//   - KEY_CLR = 4'hE, KEY_VIEW = 4'hF, view_t enum {VIEW_QR, VIEW_AB}.
//  Sub-module hex_entry #(W):
//   - Shift register plus digit counter; outputs value, count, full.
//   - Instanced twice (A, B).
//  FSM, timeout counter and display mux stay in divisor_ctrl.
// TESTING
//  Keys 4,2,0,8 -> div_start 1 pulse, div_a=8'h42, div_b=8'h08; model done q=08 r=02 -> disp_value=16'h0802, blank=0.
//  Keys 1,0,0,0 (B=0) -> no div_start, disp_err=1; key 5 -> LOAD_A, A=8'h05, disp_err=0.
//  Keys 4,2 then '*' then 9,3,0,3 -> div_a=8'h93, div_b=8'h03; q=31 r=00 -> disp_value=16'h3100.
//  Model never asserts div_done -> disp_err=1 exactly TIMEOUT cycles after div_start.
//  '*' during WAIT, then done arrives -> done ignored, disp_value=0, all blank; then '#' -> no change.
//  In SHOW press '#' -> disp_value=16'h4208; '#' again -> 16'h0802; rst=1 mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and key codes for the keypad/divider sequencer.
// Imported by divisor_ctrl and hex_entry.
package divisor_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CHECK,
    START,
    WAIT,
    SHOW,
    ERR
  } ctrl_state_t;

  typedef enum logic {
    VIEW_QR,
    VIEW_AB
  } view_t;

  localparam logic [3:0] KEY_CLR  = 4'hE;
  localparam logic [3:0] KEY_VIEW = 4'hF;

  // Bits needed to hold a digit count from 0 up to and including `digits`.
  function automatic int count_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/hex_entry.sv
// Hex operand entry: left-shifting nibble register with a count of digits typed so far.
// A clear empties it; a load restarts it holding a single digit.
module hex_entry
  import divisor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          load,
  input  logic                          shift,
  input  logic [3:0]                    digit,
  output logic [W-1:0]                  value,
  output logic [count_width(W/4)-1:0]   count,
  output logic                          full
);

  localparam int DIGITS = W / 4;
  localparam int CW     = count_width(DIGITS);

  logic [W-1:0]  value_reg;
  logic [CW-1:0] count_reg;
  logic [W+3:0]  shifted;

  assign shifted = {value_reg, digit};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_reg <= '0;
      count_reg <= '0;
    end else if (load) begin
      value_reg <= W'(digit);
      count_reg <= CW'(1);
    end else if (shift) begin
      value_reg <= shifted[W-1:0];
      count_reg <= count_reg + 1'b1;
    end
  end

  assign value = value_reg;
  assign count = count_reg;
  assign full  = (count_reg == CW'(DIGITS));

endmodule

// File: rtl/divisor_ctrl.sv
// Keypad-to-divider sequencer: gathers operands A and B, launches one division,
// then presents quotient/remainder, the operands, or an error to the display.
module divisor_ctrl
  import divisor_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               div_busy,
  input  logic               div_done,
  input  logic [W-1:0]       div_q,
  input  logic [W-1:0]       div_r,
  output logic               div_start,
  output logic [W-1:0]       div_a,
  output logic [W-1:0]       div_b,
  output logic [2*W-1:0]     disp_value,
  output logic [2*W/4-1:0]   disp_blank,
  output logic               disp_err
);

  localparam int DIGITS = W / 4;
  localparam int CW     = count_width(DIGITS);
  localparam int TW     = $clog2(TIMEOUT);

  ctrl_state_t   state_reg, state_next;
  view_t         view_reg, view_next;
  logic          drop_reg, drop_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [W-1:0]  q_reg, q_next, r_reg, r_next;

  logic          a_clr, a_load, a_shift, b_clr, b_shift;
  logic [W-1:0]  a_value, b_value;
  logic [CW-1:0] a_count, b_count;
  logic          a_full, b_full;
  logic [DIGITS-1:0] a_shown, b_shown;

  logic key_digit, key_clear, key_view;

  assign key_digit = key_valid && (key_code < KEY_CLR);
  assign key_clear = key_valid && (key_code == KEY_CLR);
  assign key_view  = key_valid && (key_code == KEY_VIEW);

  hex_entry #(.W(W)) u_entry_a (
    .clk   (clk),
    .rst   (rst),
    .clr   (a_clr),
    .load  (a_load),
    .shift (a_shift),
    .digit (key_code),
    .value (a_value),
    .count (a_count),
    .full  (a_full)
  );

  hex_entry #(.W(W)) u_entry_b (
    .clk   (clk),
    .rst   (rst),
    .clr   (b_clr),
    .load  (1'b0),
    .shift (b_shift),
    .digit (key_code),
    .value (b_value),
    .count (b_count),
    .full  (b_full)
  );

  // Digits are shifted in from the right, so the entered ones occupy the low nibbles.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
    assign a_shown[gi] = (a_count > CW'(gi));
    assign b_shown[gi] = (b_count > CW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD_A;
      view_reg  <= VIEW_QR;
      drop_reg  <= 1'b0;
      timer_reg <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      view_reg  <= view_next;
      drop_reg  <= drop_next;
      timer_reg <= timer_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    view_next  = view_reg;
    drop_next  = drop_reg;
    timer_next = timer_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_shift    = 1'b0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;

    if (div_done) drop_next = 1'b0;

    if (key_clear) begin
      state_next = LOAD_A;
      view_next  = VIEW_QR;
      a_clr      = 1'b1;
      b_clr      = 1'b1;
      // An abandoned division still owes us a done, unless it is landing right now.
      if ((state_reg == START) || ((state_reg == WAIT) && !(div_done && !drop_reg)))
        drop_next = 1'b1;
    end else begin
      case (state_reg)
        LOAD_A: if (key_digit && !a_full) begin
          a_shift = 1'b1;
          if (a_count == CW'(DIGITS - 1)) state_next = LOAD_B;
        end
        LOAD_B: if (key_digit && !b_full) begin
          b_shift = 1'b1;
          if (b_count == CW'(DIGITS - 1)) state_next = CHECK;
        end
        CHECK: state_next = (b_value == '0) ? ERR : START;
        START: if (!div_busy) begin
          state_next = WAIT;
          // Timer counts cycles since the start pulse, which itself is cycle 0.
          timer_next = TW'(1);
        end
        WAIT: begin
          if (div_done && !drop_reg) begin
            q_next     = div_q;
            r_next     = div_r;
            view_next  = VIEW_QR;
            state_next = SHOW;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            state_next = ERR;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        SHOW: begin
          if (key_view) begin
            view_next = (view_reg == VIEW_QR) ? VIEW_AB : VIEW_QR;
          end else if (key_digit) begin
            a_load     = 1'b1;
            b_clr      = 1'b1;
            state_next = LOAD_A;
          end
        end
        ERR: if (key_digit) begin
          a_load     = 1'b1;
          b_clr      = 1'b1;
          state_next = LOAD_A;
        end
        default: state_next = LOAD_A;
      endcase
    end
  end

  assign div_start = (state_reg == START) && !div_busy && !rst;
  assign div_a     = a_value;
  assign div_b     = b_value;

  always_comb begin
    disp_value = '0;
    disp_blank = '1;
    disp_err   = 1'b0;
    case (state_reg)
      LOAD_A, LOAD_B: begin
        disp_value = {a_value, b_value};
        disp_blank = {~a_shown, ~b_shown};
      end
      CHECK, START, WAIT: begin
        disp_value = {a_value, b_value};
        disp_blank = '0;
      end
      SHOW: begin
        disp_value = (view_reg == VIEW_QR) ? {q_reg, r_reg} : {a_value, b_value};
        disp_blank = '0;
      end
      ERR: begin
        disp_err   = 1'b1;
        disp_blank = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divisor_ctrl.sv
// Bench for divisor_ctrl: a behavioural divider plus a digit-queue reference model,
// directed scenarios with literal expectations, then randomized key/done traffic.
module tb_divisor_ctrl;

  localparam int W       = 8;
  localparam int D       = W / 4;
  localparam int TIMEOUT = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           key_valid = 1'b0;
  logic [3:0]     key_code = 4'h0;
  logic           div_busy = 1'b0;
  logic           div_done = 1'b0;
  logic [W-1:0]   div_q = '0;
  logic [W-1:0]   div_r = '0;
  logic           div_start;
  logic [W-1:0]   div_a, div_b;
  logic [2*W-1:0] disp_value;
  logic [2*D-1:0] disp_blank;
  logic           disp_err;

  always #5 clk = ~clk;

  divisor_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_q      (div_q),
    .div_r      (div_r),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .disp_value (disp_value),
    .disp_blank (disp_blank),
    .disp_err   (disp_err)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  // Reference model: operands are just the list of digits typed since the last clear.
  typedef enum {P_ENTRY, P_DECIDE, P_ISSUE, P_AWAIT, P_RESULT, P_FAULT} phase_t;
  phase_t       ph = P_ENTRY;
  int           digs[$];
  logic [W-1:0] mq = '0, mr = '0;
  bit           show_ab = 0, discard = 0;
  int           waited = 0;

  logic [2*W-1:0] e_value;
  logic [2*D-1:0] e_blank;
  logic           e_err, e_start;
  logic [W-1:0]   e_a, e_b;

  // Base-16 value of digits [lo, hi) that have been typed so far.
  function automatic logic [W-1:0] fold(input int lo, input int hi);
    logic [W-1:0] v;
    v = '0;
    for (int i = lo; i < hi && i < digs.size(); i++) v = W'(v * 16 + digs[i]);
    return v;
  endfunction

  task automatic model_step();
    bit dg, cl, vw, old_drop;
    dg = key_valid && (key_code <= 4'hD);
    cl = key_valid && (key_code == 4'hE);
    vw = key_valid && (key_code == 4'hF);
    if (rst) begin
      ph = P_ENTRY; digs.delete(); show_ab = 0; discard = 0; waited = 0; mq = '0; mr = '0;
    end else begin
      old_drop = discard;
      if (div_done) discard = 0;
      if (cl) begin
        if (ph == P_ISSUE || (ph == P_AWAIT && !(div_done && !old_drop))) discard = 1;
        ph = P_ENTRY; digs.delete(); show_ab = 0;
      end else begin
        case (ph)
          P_ENTRY: if (dg) begin
            digs.push_back(int'(key_code));
            if (digs.size() == 2 * D) ph = P_DECIDE;
          end
          P_DECIDE: ph = (fold(D, 2 * D) == '0) ? P_FAULT : P_ISSUE;
          P_ISSUE: if (!div_busy) begin ph = P_AWAIT; waited = 0; end
          P_AWAIT: begin
            waited++;
            if (div_done && !old_drop) begin
              mq = div_q; mr = div_r; show_ab = 0; ph = P_RESULT;
            end else if (waited >= TIMEOUT - 1) begin
              ph = P_FAULT;
            end
          end
          P_RESULT: begin
            if (vw) show_ab = !show_ab;
            else if (dg) begin digs.delete(); digs.push_back(int'(key_code)); ph = P_ENTRY; end
          end
          P_FAULT: if (dg) begin digs.delete(); digs.push_back(int'(key_code)); ph = P_ENTRY; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compute_expect();
    int n, ka, kb;
    logic [W-1:0] a, b;
    n  = digs.size();
    a  = fold(0, D);
    b  = fold(D, 2 * D);
    ka = (n < D) ? n : D;
    kb = (n > D) ? n - D : 0;
    e_a = a; e_b = b; e_err = 1'b0; e_value = {a, b}; e_blank = '0;
    e_start = (ph == P_ISSUE) && !div_busy && !rst;
    case (ph)
      P_ENTRY: for (int i = 0; i < D; i++) begin
        e_blank[D + i] = (i >= ka);
        e_blank[i]     = (i >= kb);
      end
      P_RESULT: if (!show_ab) e_value = {mq, mr};
      P_FAULT: begin e_err = 1'b1; e_value = '0; end
      default: ;
    endcase
  endtask

  int cyc = 0;
  always @(negedge clk) begin
    if (checking) begin
      compute_expect();
      vectors++;
      if (disp_value !== e_value) begin
        miscompares++; $display("FAIL disp_value t=%0t got=%h exp=%h", $time, disp_value, e_value);
      end
      if (disp_blank !== e_blank) begin
        miscompares++; $display("FAIL disp_blank t=%0t got=%b exp=%b", $time, disp_blank, e_blank);
      end
      if (disp_err !== e_err) begin
        miscompares++; $display("FAIL disp_err t=%0t got=%b exp=%b", $time, disp_err, e_err);
      end
      if (div_start !== e_start) begin
        miscompares++; $display("FAIL div_start t=%0t got=%b exp=%b", $time, div_start, e_start);
      end
      if (div_a !== e_a || div_b !== e_b) begin
        miscompares++; $display("FAIL div_ab t=%0t got=%h/%h exp=%h/%h", $time, div_a, div_b, e_a, e_b);
      end
    end
  end

  // Behavioural divider environment.
  int           busy_left = 0;
  int           lat_cfg = 3;
  bit           hang = 0, inject = 0;
  bit           started, err_now;
  int           starts = 0, last_start_cyc = 0;
  logic [W-1:0] st_a, st_b, op_a, op_b;

  task automatic tick();
    @(negedge clk);
    cyc++;
    started = (div_start === 1'b1);
    err_now = (disp_err === 1'b1);
    if (started) begin starts++; last_start_cyc = cyc; st_a = div_a; st_b = div_b; end
    @(posedge clk);
    model_step();
    #1;
    key_valid = 1'b0;
    div_done  = 1'b0;
    if (started && !div_busy) begin
      div_busy  = 1'b1; op_a = st_a; op_b = st_b;
      busy_left = (lat_cfg > 0) ? lat_cfg : $urandom_range(1, 12);
    end else if (div_busy) begin
      busy_left--;
      if (busy_left == 0) begin
        div_busy = 1'b0;
        if (!hang) begin
          div_done = 1'b1;
          div_q = (op_b == '0) ? '1 : op_a / op_b;
          div_r = (op_b == '0) ? '1 : op_a % op_b;
        end
      end
    end else if (inject) begin
      div_done = 1'b1; div_q = W'($urandom); div_r = W'($urandom);
    end
    inject = 0;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_start(input string name, output int lat);
    int s0;
    s0 = starts; lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (starts != s0) begin lat = i; break; end
    end
    if (lat < 0) begin
      vectors++; miscompares++; $display("FAIL %s no div_start within 12 cycles", name);
    end
  endtask

  initial begin
    int lat, s0, gap;
    tick();
    checking = 1;
    tick();
    rst = 1'b0;
    check("reset_value", 32'(disp_value), 32'h0);
    check("reset_blank", 32'(disp_blank), 32'hF);
    check("reset_err", 32'(disp_err), 32'h0);
    check("reset_start", 32'(div_start), 32'h0);

    // 42 / 08
    s0 = starts;
    press(4); press(2); press(0); press(8);
    wait_start("t1", lat);
    check("key_to_start_latency", lat, 2);
    check("t1_div_a", 32'(st_a), 32'h42);
    check("t1_div_b", 32'(st_b), 32'h08);
    idle(8);
    check("t1_disp", 32'(disp_value), 32'h0802);
    check("t1_blank", 32'(disp_blank), 32'h0);
    check("t1_one_start", starts - s0, 1);

    press(4'hF);
    check("view_ab", 32'(disp_value), 32'h4208);
    press(4'hF);
    check("view_qr", 32'(disp_value), 32'h0802);

    // Zero divisor
    s0 = starts;
    press(1); press(0); press(0); press(0);
    idle(3);
    check("b0_err", 32'(disp_err), 32'h1);
    check("b0_no_start", starts - s0, 0);
    press(5);
    check("restart_err", 32'(disp_err), 32'h0);
    check("restart_a", 32'(div_a), 32'h05);
    check("restart_disp", 32'(disp_value), 32'h0500);
    check("restart_blank", 32'(disp_blank), 32'hB);

    // Clear in the middle of entry
    press(4'hE); press(4); press(2); press(4'hE);
    press(9); press(3); press(0); press(3);
    wait_start("t3", lat);
    check("t3_div_a", 32'(st_a), 32'h93);
    check("t3_div_b", 32'(st_b), 32'h03);
    idle(8);
    check("t3_disp", 32'(disp_value), 32'h3100);

    // Clear while waiting; the late done must be dropped
    lat_cfg = 8;
    press(1); press(2); press(0); press(3);
    wait_start("t5", lat);
    idle(2);
    press(4'hE);
    idle(12);
    check("drop_disp", 32'(disp_value), 32'h0);
    check("drop_blank", 32'(disp_blank), 32'hF);
    press(4'hF);
    check("drop_view_disp", 32'(disp_value), 32'h0);
    check("drop_view_blank", 32'(disp_blank), 32'hF);

    // Divider never answers
    lat_cfg = 3; hang = 1;
    press(6); press(4); press(0); press(2);
    wait_start("timeout", lat);
    gap = -1;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      tick();
      if (err_now) begin gap = cyc - last_start_cyc; break; end
    end
    check("timeout_gap", gap, TIMEOUT);
    hang = 0;
    press(4'hE);
    idle(2);

    // Reset while waiting
    lat_cfg = 10;
    press(5); press(5); press(0); press(2);
    wait_start("rst_wait", lat);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_value", 32'(disp_value), 32'h0);
    check("rst_blank", 32'(disp_blank), 32'hF);
    check("rst_err", 32'(disp_err), 32'h0);
    check("rst_a", 32'(div_a), 32'h0);
    check("rst_b", 32'(div_b), 32'h0);
    check("rst_start", 32'(div_start), 32'h0);
    idle(12);

    // Randomized traffic
    lat_cfg = 0;
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) press(4'($urandom_range(0, 13)));
      else if (r < 61) press(4'hE);
      else if (r < 71) press(4'hF);
      else if (r < 75) begin inject = 1; tick(); end
      else if (r < 76) begin rst = 1'b1; tick(); rst = 1'b0; end
      else idle($urandom_range(1, 4));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
